// File: rtl/scarv_ram_pkg.sv
// Shared types and helpers for the multi-port RAM: default geometry, response
// payload layout and flat-bus slicing.
package scarv_ram_pkg;

  localparam int DW         = 32;
  localparam int BYTE_LANES = DW / 8;
  localparam int SW         = BYTE_LANES;
  localparam int AW         = 12;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  // Low bit of port p's field in a flat per-port bus of w-bit fields.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction

  // Address/pointer width that stays legal for single-entry structures.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scarv_ram_rsp_fifo.sv
// First-word-fall-through response FIFO, one per RAM port. The head entry is
// visible on o_data whenever o_count is non-zero; pops of an empty FIFO are ignored.
module scarv_ram_rsp_fifo
  import scarv_ram_pkg::*;
#(
  parameter int  DEPTH     = 2,
  parameter type payload_t = rsp_t,
  localparam int PTR_W     = clog2_min1(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             i_push,
  input  payload_t         i_data,
  input  logic             i_pop,
  output payload_t         o_data,
  output logic [CNT_W-1:0] o_count
);

  payload_t         r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (r_count != CNT_W'(DEPTH));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (w_push) r_buf[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_buf[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/scarv_mport_ram.sv
// N-port byte-strobed RAM with req/gnt handshake, RD_LAT response pipeline and
// per-port response FIFOs. Define SCARV_RAM_COLLISION_EN to flag writes that
// lose bytes to a lower-index port in the same cycle (rsp_err); otherwise rsp_err is 0.
// INIT_FILE is kept for drop-in compatibility; contents are preloaded externally.
module scarv_mport_ram
  import scarv_ram_pkg::*;
#(
  parameter int    PORTS     = 2,
  parameter int    DEPTH     = 4096,
  parameter int    WIDTH     = DW,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = "",
  localparam int   LANES     = WIDTH / 8,
  localparam int   ADDR_W    = clog2_min1(DEPTH)
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,
  input  logic [PORTS-1:0]        req,
  output logic [PORTS-1:0]        gnt,
  input  logic [PORTS-1:0]        wen,
  input  logic [PORTS*LANES-1:0]  strb,
  input  logic [PORTS*ADDR_W-1:0] addr,
  input  logic [PORTS*WIDTH-1:0]  wdata,
  output logic [PORTS-1:0]        rsp_valid,
  input  logic [PORTS-1:0]        rsp_ready,
  output logic [PORTS*WIDTH-1:0]  rsp_rdata,
  output logic [PORTS-1:0]        rsp_err
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] rdata;
  } port_rsp_t;

  localparam int                FIFO_D  = RD_LAT + 1;
  localparam int                CNT_W   = $clog2(FIFO_D + 1);
  localparam int                OUT_W   = $clog2(RD_LAT + 2);
  localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(RD_LAT + 1);

  logic [WIDTH-1:0]  r_mem   [DEPTH];
  logic [ADDR_W-1:0] w_addr  [PORTS];
  logic [LANES-1:0]  w_strb  [PORTS];
  logic [WIDTH-1:0]  w_wdata [PORTS];
  logic [PORTS-1:0]  w_acc;
  logic [PORTS-1:0]  w_wr;
  logic [PORTS-1:0]  w_lost;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_unpack
    assign w_addr[gi]  = addr[slice_lo(gi, ADDR_W) +: ADDR_W];
    assign w_strb[gi]  = strb[slice_lo(gi, LANES) +: LANES];
    assign w_wdata[gi] = wdata[slice_lo(gi, WIDTH) +: WIDTH];
  end

  assign w_acc = req & gnt;
  assign w_wr  = w_acc & wen;

`ifdef SCARV_RAM_COLLISION_EN
  always_comb begin
    w_lost = '0;
    for (int p = 1; p < PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (w_wr[p] && w_wr[q] && (w_addr[p] == w_addr[q]) &&
            ((w_strb[p] & w_strb[q]) != '0)) begin
          w_lost[p] = 1'b1;
        end
      end
    end
  end
`else
  assign w_lost = '0;
`endif

  // Per-lane priority: ports are scanned high to low so the lowest index lands last.
  always_ff @(posedge g_clk) begin
    for (int p = PORTS - 1; p >= 0; p--) begin
      for (int b = 0; b < LANES; b++) begin
        if (w_wr[p] && w_strb[p][b]) begin
          r_mem[w_addr[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
        end
      end
    end
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    port_rsp_t        w_rsp_in;
    port_rsp_t        w_push_data;
    port_rsp_t        w_head;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic [OUT_W-1:0] r_out;

    // Captured at the accept edge, before that edge's writes land: read-first.
    assign w_rsp_in = {w_lost[gi], r_mem[w_addr[gi]]};

    if (RD_LAT == 1) begin : g_lat1
      assign w_push      = w_acc[gi];
      assign w_push_data = w_rsp_in;
    end else begin : g_lat2
      logic      r_pipe_vld;
      port_rsp_t r_pipe_data;

      always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
          r_pipe_vld  <= 1'b0;
          r_pipe_data <= '0;
        end else begin
          r_pipe_vld  <= w_acc[gi];
          r_pipe_data <= w_rsp_in;
        end
      end

      assign w_push      = r_pipe_vld;
      assign w_push_data = r_pipe_data;
    end

    scarv_ram_rsp_fifo #(
      .DEPTH     (FIFO_D),
      .payload_t (port_rsp_t)
    ) u_fifo (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .i_push   (w_push),
      .i_data   (w_push_data),
      .i_pop    (rsp_ready[gi]),
      .o_data   (w_head),
      .o_count  (w_count)
    );

    assign rsp_valid[gi] = (w_count != '0);
    assign w_pop         = rsp_valid[gi] & rsp_ready[gi];

    // Outstanding = pipeline + FIFO occupancy; bounding it keeps the FIFO from overflowing.
    always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
        r_out <= '0;
      end else begin
        case ({w_acc[gi], w_pop})
          2'b10:   r_out <= r_out + OUT_W'(1);
          2'b01:   r_out <= r_out - OUT_W'(1);
          default: r_out <= r_out;
        endcase
      end
    end

    assign gnt[gi] = g_resetn && (r_out < OUT_MAX);
    assign rsp_rdata[slice_lo(gi, WIDTH) +: WIDTH] = rsp_valid[gi] ? w_head.rdata : '0;
    assign rsp_err[gi] = rsp_valid[gi] & w_head.err;
  end

endmodule

// File: tb/tb_scarv_mport_ram.sv
// Bench for scarv_mport_ram: two instances (RD_LAT=1 and RD_LAT=2) checked every
// cycle against a queue-based reference model, plus table vectors and corner sequences.
module tb_scarv_mport_ram;

  localparam int P  = 2;
  localparam int D  = 64;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int AW = 6;
`ifdef SCARV_RAM_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [P-1:0]    req       [2];
  logic [P-1:0]    gnt       [2];
  logic [P-1:0]    wen       [2];
  logic [P*L-1:0]  strb      [2];
  logic [P*AW-1:0] addr      [2];
  logic [P*W-1:0]  wdata     [2];
  logic [P-1:0]    rsp_valid [2];
  logic [P-1:0]    rsp_ready [2];
  logic [P*W-1:0]  rsp_rdata [2];
  logic [P-1:0]    rsp_err   [2];

  scarv_mport_ram #(.PORTS(P), .DEPTH(D), .WIDTH(W), .RD_LAT(1), .INIT_FILE("")) u_dut1 (
    .g_clk(clk), .g_resetn(rst_n), .req(req[0]), .gnt(gnt[0]), .wen(wen[0]),
    .strb(strb[0]), .addr(addr[0]), .wdata(wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  scarv_mport_ram #(.PORTS(P), .DEPTH(D), .WIDTH(W), .RD_LAT(2), .INIT_FILE("")) u_dut2 (
    .g_clk(clk), .g_resetn(rst_n), .req(req[1]), .gnt(gnt[1]), .wen(wen[1]),
    .strb(strb[1]), .addr(addr[1]), .wdata(wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic        err;
    int          vis;
  } exp_t;

  typedef struct {
    int          p;
    bit          w;
    logic [3:0]  s;
    logic [5:0]  a;
    logic [31:0] d;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  exp_t        expq    [4][$];
  logic [31:0] mem_m   [2][D];
  logic [3:0]  known_m [2][D];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int k, input int p,
                              input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d p%0d: got %h want %h (cycle %0d)", name, k, p, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] bytemask(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic void check_outputs();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < P; p++) begin
        int   qi;
        logic eg;
        logic ev;
        logic [31:0] m;
        qi = k * 2 + p;
        eg = rst_n && (expq[qi].size() < k + 2);
        ev = (expq[qi].size() > 0) && (expq[qi][0].vis <= cyc);
        chk("gnt", k, p, 32'(gnt[k][p]), 32'(eg));
        chk("rsp_valid", k, p, 32'(rsp_valid[k][p]), 32'(ev));
        if (ev) begin
          m = bytemask(expq[qi][0].mask);
          chk("rsp_rdata", k, p, rsp_rdata[k][p*W +: W] & m, expq[qi][0].rdata & m);
          chk("rsp_err", k, p, 32'(rsp_err[k][p]), 32'(expq[qi][0].err));
        end else if (!rst_n) begin
          chk("rst_rdata", k, p, rsp_rdata[k][p*W +: W], 32'h0);
          chk("rst_err", k, p, 32'(rsp_err[k][p]), 32'h0);
        end
      end
    end
  endfunction

  // Reference: responses are the word before this cycle's writes; each byte
  // goes to the lowest-index port that strobed it.
  function automatic void model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) expq[i].delete();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      bit acc [P];
      bit ev  [P];
      for (int p = 0; p < P; p++) begin
        int qi;
        qi = k * 2 + p;
        acc[p] = req[k][p] && (expq[qi].size() < k + 2);
        ev[p]  = (expq[qi].size() > 0) && (expq[qi][0].vis <= cyc);
      end
      for (int p = 0; p < P; p++) begin
        if (ev[p] && rsp_ready[k][p]) void'(expq[k*2+p].pop_front());
      end
      for (int p = 0; p < P; p++) begin
        if (acc[p]) begin
          exp_t e;
          logic [AW-1:0] a;
          a = addr[k][p*AW +: AW];
          e.rdata = mem_m[k][a];
          e.mask  = known_m[k][a];
          e.err   = 1'b0;
          e.vis   = cyc + k + 1;
          if (wen[k][p] && COLL) begin
            for (int q = 0; q < p; q++) begin
              if (acc[q] && wen[k][q] && (addr[k][q*AW +: AW] == a) &&
                  ((strb[k][q*L +: L] & strb[k][p*L +: L]) != 4'h0)) e.err = 1'b1;
            end
          end
          expq[k*2+p].push_back(e);
        end
      end
      for (int a = 0; a < D; a++) begin
        for (int b = 0; b < L; b++) begin
          for (int p = 0; p < P; p++) begin
            if (acc[p] && wen[k][p] && strb[k][p*L+b] && (addr[k][p*AW +: AW] == AW'(a))) begin
              mem_m[k][a][b*8 +: 8] = wdata[k][p*W + b*8 +: 8];
              known_m[k][a][b] = 1'b1;
              break;
            end
          end
        end
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) req[k] = '0;
  endtask

  task automatic set_op(input int k, input int p, input bit w, input logic [3:0] s,
                        input logic [5:0] a, input logic [31:0] d);
    req[k][p]          = 1'b1;
    wen[k][p]          = w;
    strb[k][p*L +: L]  = s;
    addr[k][p*AW +: AW] = a;
    wdata[k][p*W +: W] = d;
  endtask

  task automatic wait_rsp(input int k, input int p, output logic [31:0] d,
                          output logic e, output int lat);
    lat = -1;
    d = '0;
    e = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid[k][p]) begin
        d = rsp_rdata[k][p*W +: W];
        e = rsp_err[k][p];
        lat = i;
        break;
      end
      tick();
    end
    if (lat < 0) chk("rsp_timeout", k, p, 32'h0, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [9];
    logic [31:0] d;
    logic [31:0] d1;
    logic        e;
    logic        e1;
    int          lat;
    int          acc_n;
    int          drops;
    int          stale;
    int          cnt [P];

    vt[0] = '{0, 1'b1, 4'hF, 6'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1] = '{0, 1'b0, 4'h0, 6'h10, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[2] = '{0, 1'b1, 4'hF, 6'h20, 32'h11223344, 1'b0, 32'h0};
    vt[3] = '{0, 1'b1, 4'h3, 6'h20, 32'hAABBCCDD, 1'b1, 32'h11223344};
    vt[4] = '{0, 1'b0, 4'h0, 6'h20, 32'h0,        1'b1, 32'h1122CCDD};
    vt[5] = '{1, 1'b1, 4'hF, 6'h30, 32'h0,        1'b0, 32'h0};
    vt[6] = '{1, 1'b1, 4'h8, 6'h30, 32'h5A000000, 1'b1, 32'h0};
    vt[7] = '{1, 1'b0, 4'h0, 6'h30, 32'h0,        1'b1, 32'h5A000000};
    vt[8] = '{1, 1'b0, 4'h0, 6'h10, 32'h0,        1'b1, 32'hDEADBEEF};

    for (int k = 0; k < 2; k++) begin
      req[k] = '0; wen[k] = '0; strb[k] = '0; addr[k] = '0; wdata[k] = '0;
      rsp_ready[k] = '1;
      for (int a = 0; a < D; a++) begin
        mem_m[k][a] = '0;
        known_m[k][a] = '0;
      end
    end

    // Reset: outputs quiet and gnt low while held.
    @(negedge clk);
    check_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors on the RD_LAT=1 instance.
    for (int i = 0; i < 9; i++) begin
      set_op(0, vt[i].p, vt[i].w, vt[i].s, vt[i].a, vt[i].d);
      tick();
      idle();
      wait_rsp(0, vt[i].p, d, e, lat);
      $display("vec %0d: p%0d %s a=%h rdata=%h lat=%0d", i, vt[i].p, vt[i].w ? "W" : "R", vt[i].a, d, lat);
      chk("vec_lat", 0, vt[i].p, 32'(lat), 32'h0);
      if (vt[i].chk) chk("vec_rdata", 0, vt[i].p, d, vt[i].exp);
      tick();
    end

    // Known contents for words 0..15 on both instances.
    for (int a = 0; a < 16; a++) begin
      set_op(0, 0, 1'b1, 4'hF, 6'(a), 32'hC0DE0000 | 32'(a));
      set_op(1, 0, 1'b1, 4'hF, 6'(a), 32'hC0DE0000 | 32'(a));
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Same-cycle two-port write to one word, overlapping strobes.
    set_op(0, 0, 1'b1, 4'hF, 6'h4, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 2; i++) tick();
    set_op(0, 0, 1'b1, 4'h3, 6'h4, 32'h000000AA);
    set_op(0, 1, 1'b1, 4'h3, 6'h4, 32'h0000BB00);
    tick();
    idle();
    wait_rsp(0, 0, d, e, lat);
    wait_rsp(0, 1, d1, e1, lat);
    $display("collide: p0 err=%0d p1 err=%0d", e, e1);
    chk("coll_err_p0", 0, 0, 32'(e), 32'h0);
    chk("coll_err_p1", 0, 1, 32'(e1), 32'(COLL));
    tick();
    set_op(0, 0, 1'b0, 4'h0, 6'h4, 32'h0);
    tick();
    idle();
    wait_rsp(0, 0, d, e, lat);
    $display("collide readback: %h", d);
    chk("coll_word", 0, 0, d, 32'h000000AA);
    tick();

    // Backpressure on the RD_LAT=2 instance: only RD_LAT+1 reads get in.
    rsp_ready[1][0] = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      set_op(1, 0, 1'b0, 4'h0, 6'(i), 32'h0);
      if (gnt[1][0]) acc_n++;
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();
    $display("backpressure: accepted=%0d gnt=%0d valid=%0d", acc_n, gnt[1][0], rsp_valid[1][0]);
    chk("bp_accepted", 1, 0, 32'(acc_n), 32'd3);
    chk("bp_gnt_low", 1, 0, 32'(gnt[1][0]), 32'h0);
    chk("bp_valid_held", 1, 0, 32'(rsp_valid[1][0]), 32'h1);
    rsp_ready[1][0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_rsp(1, 0, d, e, lat);
      $display("bp rsp %0d: %h", j, d);
      chk("bp_order", 1, 0, d, 32'hC0DE0000 | 32'(j));
      tick();
    end
    chk("bp_gnt_back", 1, 0, 32'(gnt[1][0]), 32'h1);

    // Streaming with rsp_ready held high on both ports.
    drops = 0;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int i = 0; i < 64; i++) begin
      for (int p = 0; p < P; p++) begin
        set_op(1, p, 1'b0, 4'h0, 6'($urandom_range(0, 15)), 32'h0);
        if (!gnt[1][p]) drops++;
        if (rsp_valid[1][p]) cnt[p]++;
      end
      tick();
    end
    idle();
    for (int j = 0; j < 6; j++) begin
      for (int p = 0; p < P; p++) if (rsp_valid[1][p]) cnt[p]++;
      tick();
    end
    $display("stream: gnt drops=%0d rsp p0=%0d p1=%0d", drops, cnt[0], cnt[1]);
    chk("stream_gnt", 1, 0, 32'(drops), 32'h0);
    chk("stream_n_p0", 1, 0, 32'(cnt[0]), 32'd64);
    chk("stream_n_p1", 1, 1, 32'(cnt[1]), 32'd64);

    // Reset with two responses outstanding.
    rsp_ready[1][0] = 1'b0;
    set_op(1, 0, 1'b0, 4'h0, 6'h2, 32'h0);
    tick();
    set_op(1, 0, 1'b0, 4'h0, 6'h3, 32'h0);
    tick();
    idle();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    $display("mid reset: valid=%0d gnt=%0d", rsp_valid[1][0], gnt[1][0]);
    chk("rst_valid_now", 1, 0, 32'(rsp_valid[1][0]), 32'h0);
    chk("rst_gnt_now", 1, 0, 32'(gnt[1][0]), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready[1][0] = 1'b1;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid[1][0]) stale++;
    end
    chk("rst_stale", 1, 0, 32'(stale), 32'h0);
    set_op(1, 0, 1'b0, 4'h0, 6'h1, 32'h0);
    tick();
    idle();
    wait_rsp(1, 0, d, e, lat);
    $display("post reset read: %h lat=%0d", d, lat);
    chk("rst_mem_kept", 1, 0, d, 32'hC0DE0001);
    chk("rst_read_lat", 1, 0, 32'(lat), 32'h1);
    tick();

    // Random traffic on both instances, every cycle checked by the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < P; p++) begin
          req[k][p]       = ($urandom_range(0, 3) != 0);
          rsp_ready[k][p] = ($urandom_range(0, 9) < 7);
          set_op(k, p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 6'($urandom_range(0, 7)), $urandom);
          req[k][p]       = ($urandom_range(0, 3) != 0);
        end
      end
      tick();
    end
    idle();
    for (int k = 0; k < 2; k++) rsp_ready[k] = '1;
    for (int i = 0; i < 8; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
